// File: rtl/halt_monitor.sv
// halt_monitor
//   Run monitor sitting between the core's halt output / word-0 memory tap and
//   the top-level reporting logic. Counts cycles from reset release, latches the
//   first halt together with word 0 and the cycle it happened on, then requires
//   halt and word 0 to hold steady for SETTLE cycles before flagging done.
//   Timeout, halt drop and word corruption end the run as a fault, so FPGA runs
//   report the same pass/fail as simulation.
// Ports
//   clk         system clock, all state on rising edge
//   rstn        asynchronous active-low reset
//   coreHalt    core halt level
//   memWord0    current contents of memory word 0
//   haltSticky  set at first halt capture, held until reset
//   snapWord    memWord0 sampled at the halt-capture edge
//   cycleCnt    rising edges since reset release, frozen in DONE/FAULT
//   haltCycle   cycleCnt value written at the halt-capture edge
//   done        settle window passed cleanly, held until reset
//   fault       error detected, held until reset
//   faultCode   0 none, 1 timeout, 2 halt dropped, 3 word changed
module halt_monitor #(
   parameter int unsigned TIMEOUT = 500,
   parameter int unsigned SETTLE  = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             coreHalt,
   input  logic [15:0]      memWord0,
   output logic             haltSticky,
   output logic [15:0]      snapWord,
   output logic [CNT_W-1:0] cycleCnt,
   output logic [CNT_W-1:0] haltCycle,
   output logic             done,
   output logic             fault,
   output logic [1:0]       faultCode
);

   generate
      if (SETTLE < 1) begin : gBadSettle
         $error("halt_monitor: SETTLE must be at least 1");
      end
   endgenerate

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;

   localparam int unsigned    SC_W      = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [SC_W-1:0]  SETTLE_C  = SC_W'(SETTLE);

   localparam logic [1:0] FC_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_DROP    = 2'd2;
   localparam logic [1:0] FC_WORD    = 2'd3;

   logic [1:0]       state;
   logic [SC_W-1:0]  settleCnt;
   logic [CNT_W-1:0] cntNext;
   logic [SC_W-1:0]  settleNext;

   // Saturating count: holds at all-ones rather than wrapping back to a
   // value that could look like an early halt.
   always_comb begin
      cntNext    = (cycleCnt == '1) ? cycleCnt : cycleCnt + CNT_W'(1);
      settleNext = settleCnt + SC_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_RUN;
         settleCnt  <= '0;
         haltSticky <= 1'b0;
         snapWord   <= '0;
         cycleCnt   <= '0;
         haltCycle  <= '0;
         done       <= 1'b0;
         fault      <= 1'b0;
         faultCode  <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               cycleCnt <= cntNext;
               // Halt is checked first so a halt on the timeout edge still wins.
               if (coreHalt) begin
                  snapWord   <= memWord0;
                  haltCycle  <= cntNext;
                  haltSticky <= 1'b1;
                  settleCnt  <= '0;
                  state      <= ST_SETTLE;
               end else if (cntNext > TIMEOUT_C) begin
                  fault     <= 1'b1;
                  faultCode <= FC_TIMEOUT;
                  state     <= ST_FAULT;
               end
            end
            ST_SETTLE: begin
               cycleCnt <= cntNext;
               if (!coreHalt) begin
                  fault     <= 1'b1;
                  faultCode <= FC_DROP;
                  state     <= ST_FAULT;
               end else if (memWord0 != snapWord) begin
                  fault     <= 1'b1;
                  faultCode <= FC_WORD;
                  state     <= ST_FAULT;
               end else begin
                  settleCnt <= settleNext;
                  if (settleNext == SETTLE_C) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            default: ;  // DONE / FAULT are terminal: everything holds
         endcase
      end
   end

endmodule

// File: tb/tb_halt_monitor.sv
// Directed bench for halt_monitor: reset state, clean halt, timeout, halt drop,
// word change, halt on the last accepted cycle, and reset during SETTLE.
module tb_halt_monitor;

   logic        clk = 1'b0;
   logic        rstn;
   logic        coreHalt;
   logic [15:0] memWord0;
   logic        haltSticky;
   logic [15:0] snapWord;
   logic [31:0] cycleCnt;
   logic [31:0] haltCycle;
   logic        done;
   logic        fault;
   logic [1:0]  faultCode;

   int nVec  = 0;
   int nMiss = 0;
   int edgeNo = 0;

   halt_monitor #(.TIMEOUT(500), .SETTLE(5), .CNT_W(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .coreHalt   (coreHalt),
      .memWord0   (memWord0),
      .haltSticky (haltSticky),
      .snapWord   (snapWord),
      .cycleCnt   (cycleCnt),
      .haltCycle  (haltCycle),
      .done       (done),
      .fault      (fault),
      .faultCode  (faultCode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance until edge n has occurred, then park on the following negedge.
   task automatic runTo(input int n);
      while (edgeNo < n) begin
         @(posedge clk);
         edgeNo++;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rstn     = 1'b0;
      coreHalt = 1'b0;
      memWord0 = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      rstn   = 1'b1;
      edgeNo = 0;
   endtask

   task automatic chkOut(input string tag, input logic d, input logic f,
                         input logic [1:0] fc, input logic [31:0] cc);
      chk({tag, ".done"},      {31'd0, done},      {31'd0, d});
      chk({tag, ".fault"},     {31'd0, fault},     {31'd0, f});
      chk({tag, ".faultCode"}, {30'd0, faultCode}, {30'd0, fc});
      chk({tag, ".cycleCnt"},  cycleCnt,           cc);
   endtask

   // Halt rises before edge 40 with a stable word; done at 45.
   task automatic runT1(input string tag);
      runTo(39);
      coreHalt = 1'b1;
      runTo(40);
      chk({tag, ".sticky"},    {31'd0, haltSticky}, 32'd1);
      chk({tag, ".haltCycle"}, haltCycle, 32'd40);
      chk({tag, ".snap"},      {16'd0, snapWord}, 32'h1234);
      runTo(44);
      chkOut({tag, "@44"}, 1'b0, 1'b0, 2'd0, 32'd44);
      runTo(45);
      chkOut({tag, "@45"}, 1'b1, 1'b0, 2'd0, 32'd45);
      coreHalt = 1'b0;
      memWord0 = 16'hdead;
      runTo(50);
      chkOut({tag, "@50hold"}, 1'b1, 1'b0, 2'd0, 32'd45);
      chk({tag, ".snapHold"}, {16'd0, snapWord}, 32'h1234);
   endtask

   initial begin
      rstn     = 1'b0;
      coreHalt = 1'b0;
      memWord0 = 16'h1234;
      #2;
      // Reset state
      chkOut("rst", 1'b0, 1'b0, 2'd0, 32'd0);
      chk("rst.sticky",    {31'd0, haltSticky}, 32'd0);
      chk("rst.haltCycle", haltCycle, 32'd0);
      chk("rst.snap",      {16'd0, snapWord}, 32'd0);

      // T1
      doReset();
      runTo(1);
      chk("T1.firstEdge", cycleCnt, 32'd1);
      runT1("T1");

      // T2: timeout on edge 501
      doReset();
      runTo(500);
      chkOut("T2@500", 1'b0, 1'b0, 2'd0, 32'd500);
      runTo(501);
      chkOut("T2@501", 1'b0, 1'b1, 2'd1, 32'd501);
      coreHalt = 1'b1;
      runTo(505);
      chkOut("T2hold", 1'b0, 1'b1, 2'd1, 32'd501);
      chk("T2.sticky", {31'd0, haltSticky}, 32'd0);

      // T3: halt dropped at edge 103
      doReset();
      runTo(99);
      coreHalt = 1'b1;
      runTo(102);
      chk("T3.haltCycle", haltCycle, 32'd100);
      chkOut("T3@102", 1'b0, 1'b0, 2'd0, 32'd102);
      coreHalt = 1'b0;
      runTo(103);
      chkOut("T3@103", 1'b0, 1'b1, 2'd2, 32'd103);

      // T4: word changes before edge 102; halt drop later must not override
      doReset();
      runTo(99);
      coreHalt = 1'b1;
      runTo(101);
      memWord0 = 16'h1235;
      runTo(102);
      chkOut("T4@102", 1'b0, 1'b1, 2'd3, 32'd102);
      coreHalt = 1'b0;
      runTo(104);
      chkOut("T4hold", 1'b0, 1'b1, 2'd3, 32'd102);

      // T5: first halt on edge 500 is accepted
      doReset();
      runTo(499);
      coreHalt = 1'b1;
      runTo(500);
      chk("T5.haltCycle", haltCycle, 32'd500);
      chkOut("T5@500", 1'b0, 1'b0, 2'd0, 32'd500);
      runTo(505);
      chkOut("T5@505", 1'b1, 1'b0, 2'd0, 32'd505);

      // T6: reset mid-SETTLE clears immediately, then T1 repeats
      doReset();
      runTo(39);
      coreHalt = 1'b1;
      runTo(42);
      chk("T6.preSticky", {31'd0, haltSticky}, 32'd1);
      rstn = 1'b0;
      #1;
      chkOut("T6rst", 1'b0, 1'b0, 2'd0, 32'd0);
      chk("T6rst.sticky",    {31'd0, haltSticky}, 32'd0);
      chk("T6rst.haltCycle", haltCycle, 32'd0);
      chk("T6rst.snap",      {16'd0, snapWord}, 32'd0);
      doReset();
      runT1("T6rerun");

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
